// File: rtl/display_7seg.sv
// Registered hex-to-seven-segment decoder with decimal point; output is {dp,g,f,e,d,c,b,a}.
// Latency 1 clock, no handshake; unknown inputs are blanked so X never reaches the pins.
module display_7seg #(
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_display,
    input  logic       dp,
    output logic [7:0] out_display
);

    // XOR mask: all-ones flips every bit for common-anode digits, including reset/blank.
    localparam logic [7:0] POLARITY = COMMON_ANODE ? 8'hFF : 8'h00;

    logic [6:0] seg;
    logic       dp_bit;
    logic [7:0] next_out;

    always_comb begin
        seg = 7'h00;
        case (in_display)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        // Any X/Z bit in the nibble blanks the digit rather than guessing a shape.
        if ((^in_display) === 1'bx) begin
            seg = 7'h00;
        end
        dp_bit   = (dp === 1'b1);
        next_out = {dp_bit, seg} ^ POLARITY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_display <= POLARITY;
        end else begin
            out_display <= next_out;
        end
    end

endmodule

// File: tb/tb_display_7seg.sv
// Bench for display_7seg: drives common-cathode and common-anode instances in parallel,
// table of vectors plus hand sequences, expected values queued and checked one edge later.
module tb_display_7seg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_display = 4'h0;
    logic       dp = 1'b0;
    logic [7:0] out_cc;
    logic [7:0] out_ca;

    always #5 clk = ~clk;

    display_7seg #(.COMMON_ANODE(1'b0)) dut_cc (
        .clk(clk), .rst(rst), .in_display(in_display), .dp(dp), .out_display(out_cc)
    );
    display_7seg #(.COMMON_ANODE(1'b1)) dut_ca (
        .clk(clk), .rst(rst), .in_display(in_display), .dp(dp), .out_display(out_ca)
    );

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] din;
        logic       dp;
        logic [7:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference for the unknown-input cases, evaluated on the value actually driven.
    function automatic logic [7:0] model(input logic r, input logic [3:0] d, input logic p);
        logic [6:0] s;
        logic       pb;
        if (r === 1'b1) return 8'h00;
        if ((^d) === 1'bx) s = 7'h00;
        else s = seg_tbl[d];
        pb = (p === 1'b1);
        return {pb, s};
    endfunction

    task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic check_out();
        sb_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries, required 1");
            return;
        end
        e = sb.pop_front();
        compare({e.name, "_cc"}, out_cc, e.exp);
        compare({e.name, "_ca"}, out_ca, ~e.exp);
        n_cmp++;
        if ($isunknown({out_cc, out_ca})) begin
            n_err++;
            $display("FAIL %s_noX: got %h/%h, required no X/Z", e.name, out_cc, out_ca);
        end
    endtask

    task automatic step(input string nm, input logic r, input logic [3:0] d, input logic p,
                        input logic [7:0] exp);
        rst        = r;
        in_display = d;
        dp         = p;
        sb.push_back('{nm, exp});
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [3:0] xd;
        logic       xp;

        vecs.push_back('{"reset0", 1'b1, 4'h8, 1'b1, 8'h00});
        vecs.push_back('{"reset1", 1'b1, 4'h8, 1'b1, 8'h00});
        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{$sformatf("sweep_%h", i), 1'b0, 4'(i), 1'b0, {1'b0, seg_tbl[i]}});
        end
        vecs.push_back('{"dp_F", 1'b0, 4'hF, 1'b1, 8'hF1});
        vecs.push_back('{"dp_0", 1'b0, 4'h0, 1'b1, 8'hBF});
        vecs.push_back('{"ca_1", 1'b0, 4'h1, 1'b0, 8'h06});
        vecs.push_back('{"ca_8dp", 1'b0, 4'h8, 1'b1, 8'hFF});
        vecs.push_back('{"dp_A", 1'b0, 4'hA, 1'b1, 8'hF7});

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst, vecs[i].din, vecs[i].dp, vecs[i].exp);
        end

        // Reset takes priority over a same-edge data change, then data appears one edge later.
        step("prio_pre", 1'b0, 4'h3, 1'b0, 8'h4F);
        step("prio_rst", 1'b1, 4'h5, 1'b0, 8'h00);
        step("prio_rel", 1'b0, 4'h5, 1'b0, 8'h6D);

        // Unknown inputs; expectation derived from whatever value the simulator actually holds.
        xd = 4'b111x; xp = 1'b1;
        step("unk_111x", 1'b0, xd, xp, model(1'b0, xd, xp));
        xd = 4'bzzzz; xp = 1'b0;
        step("unk_zzzz", 1'b0, xd, xp, model(1'b0, xd, xp));
        xd = 4'h2; xp = 1'bx;
        step("unk_dp", 1'b0, xd, xp, model(1'b0, xd, xp));

        step("recover", 1'b0, 4'h7, 1'b1, 8'h87);
        step("reset_end", 1'b1, 4'h9, 1'b1, 8'h00);

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded 50000 time units");
        $fatal(1, "timeout");
    end

endmodule
